// File: rtl/issue_select_sched.sv
// Issue-side scheduler between the reservation station and the per-class FU FIFOs.
// Each cycle it grants up to ISSUE_W ready RS entries in round-robin order. Per-class credit
// counters mirror the free slots of the ALU/LS/MULT/BR FIFOs so that no FIFO is overrun.
//
// Ports:
//   clock, reset   system clock; synchronous active-high reset
//   squash         pipeline flush: drops this cycle's grants/pops, restores full credit
//   entry_ready    per-entry valid-and-operands-ready
//   entry_class    2 bits per entry: 0=ALU 1=LS 2=MULT 3=BR
//   fifo_pop       2 bits per class: packets dequeued by that class FIFO this cycle
//   issue_valid    per-slot grant valid (slot 0 = first grant in scan order)
//   issue_idx      per-slot granted RS index (0 when the slot is invalid)
//   class_stall    registered per-class flag: next credit below ISSUE_W
//   credit         current credit per class, CredW bits each
//   credit_err     sticky credit overflow/underflow flag, cleared by reset only
module issue_select_sched #(
  parameter int unsigned RS_SIZE       = 16,
  parameter int unsigned IS_FIFO_DEPTH = 8,
  parameter int unsigned ISSUE_W       = 3
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 squash,
  input  logic [RS_SIZE-1:0]                   entry_ready,
  input  logic [2*RS_SIZE-1:0]                 entry_class,
  input  logic [7:0]                           fifo_pop,
  output logic [ISSUE_W-1:0]                   issue_valid,
  output logic [ISSUE_W*$clog2(RS_SIZE)-1:0]   issue_idx,
  output logic [3:0]                           class_stall,
  output logic [4*$clog2(IS_FIFO_DEPTH+1)-1:0] credit,
  output logic                                 credit_err
);

  localparam int unsigned IdxW  = $clog2(RS_SIZE);
  localparam int unsigned CredW = $clog2(IS_FIFO_DEPTH + 1);
  localparam int unsigned CntW  = $clog2(ISSUE_W + 1);

  logic [IdxW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CredW-1:0] credit_q [4];
  logic [CredW-1:0] credit_d [4];
  logic [3:0]       class_stall_q, class_stall_d;
  logic             credit_err_q, credit_err_d;

  logic [1:0]       cls [RS_SIZE];
  logic [CredW-1:0] avail [4];
  logic [CntW-1:0]  grant_cnt [4];
  logic [CntW-1:0]  n_grant;
  logic [IdxW-1:0]  scan_idx, last_idx;
  int               cred_sum [4];

  always_comb begin
    for (int k = 0; k < int'(RS_SIZE); k++) begin
      cls[k] = entry_class[2*k +: 2];
    end
  end

  // Round-robin scan. Blocked entries are skipped so younger entries of other classes still go.
  always_comb begin
    issue_valid = '0;
    issue_idx   = '0;
    n_grant     = '0;
    scan_idx    = '0;
    last_idx    = rr_ptr_q;
    for (int c = 0; c < 4; c++) begin
      avail[c]     = credit_q[c];
      grant_cnt[c] = '0;
    end
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      scan_idx = rr_ptr_q + IdxW'(i);
      if (entry_ready[scan_idx] && (avail[cls[scan_idx]] != '0) &&
          (int'(n_grant) < int'(ISSUE_W))) begin
        for (int s = 0; s < int'(ISSUE_W); s++) begin
          if (int'(n_grant) == s) begin
            issue_valid[s]              = 1'b1;
            issue_idx[s*IdxW +: IdxW]   = scan_idx;
          end
        end
        avail[cls[scan_idx]]     = avail[cls[scan_idx]] - CredW'(1);
        grant_cnt[cls[scan_idx]] = grant_cnt[cls[scan_idx]] + CntW'(1);
        n_grant                  = n_grant + CntW'(1);
        last_idx                 = scan_idx;
      end
    end
    if (reset || squash) begin
      issue_valid = '0;
      issue_idx   = '0;
    end
  end

  // Pops only affect next cycle's credit; out-of-range results clamp and flag an error.
  always_comb begin
    credit_err_d = credit_err_q;
    rr_ptr_d     = (n_grant != '0) ? last_idx + IdxW'(1) : rr_ptr_q;
    for (int c = 0; c < 4; c++) begin
      cred_sum[c] = int'(credit_q[c]) + int'(fifo_pop[2*c +: 2]) - int'(grant_cnt[c]);
      if (cred_sum[c] > int'(IS_FIFO_DEPTH)) begin
        credit_d[c]  = CredW'(IS_FIFO_DEPTH);
        credit_err_d = 1'b1;
      end else if (cred_sum[c] < 0) begin
        credit_d[c]  = '0;
        credit_err_d = 1'b1;
      end else begin
        credit_d[c]  = CredW'(cred_sum[c]);
      end
      class_stall_d[c] = int'(credit_d[c]) < int'(ISSUE_W);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q      <= '0;
      class_stall_q <= '0;
      credit_err_q  <= 1'b0;
      for (int c = 0; c < 4; c++) begin
        credit_q[c] <= CredW'(IS_FIFO_DEPTH);
      end
    end else if (squash) begin
      rr_ptr_q      <= '0;
      class_stall_q <= '0;
      for (int c = 0; c < 4; c++) begin
        credit_q[c] <= CredW'(IS_FIFO_DEPTH);
      end
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      class_stall_q <= class_stall_d;
      credit_err_q  <= credit_err_d;
      for (int c = 0; c < 4; c++) begin
        credit_q[c] <= credit_d[c];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      credit[c*CredW +: CredW] = credit_q[c];
    end
  end

  assign class_stall = class_stall_q;
  assign credit_err  = credit_err_q;

endmodule

// File: tb/tb_issue_select_sched.sv
// Testbench for issue_select_sched: a scan-order reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_issue_select_sched;

  logic        clock;
  logic        reset;
  logic        squash;
  logic [15:0] entry_ready;
  logic [31:0] entry_class;
  logic [7:0]  fifo_pop;
  logic [2:0]  issue_valid;
  logic [11:0] issue_idx;
  logic [3:0]  class_stall;
  logic [15:0] credit;
  logic        credit_err;

  int n_tests = 0;
  int n_fail  = 0;

  issue_select_sched #(
    .RS_SIZE      (16),
    .IS_FIFO_DEPTH(8),
    .ISSUE_W      (3)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .squash     (squash),
    .entry_ready(entry_ready),
    .entry_class(entry_class),
    .fifo_pop   (fifo_pop),
    .issue_valid(issue_valid),
    .issue_idx  (issue_idx),
    .class_stall(class_stall),
    .credit     (credit),
    .credit_err (credit_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model state
  int       m_credit [4];
  int       m_rr;
  bit       m_err;
  logic [3:0] m_stall;
  bit       m_init = 1'b0;

  int          n, last, k, c, nx;
  int          g [4];
  logic [2:0]  ev;
  logic [11:0] ei;
  logic [15:0] ecred;

  always @(negedge clock) begin
    if (m_init) begin
      for (int j = 0; j < 4; j++) ecred[j*4 +: 4] = 4'(m_credit[j]);
      chk("credit", 32'(credit), 32'(ecred));
      chk("class_stall", 32'(class_stall), 32'(m_stall));
      chk("credit_err", 32'(credit_err), 32'(m_err));
    end
    ev   = '0;
    ei   = '0;
    n    = 0;
    last = m_rr;
    for (int j = 0; j < 4; j++) g[j] = 0;
    if (!reset && !squash) begin
      for (int i = 0; i < 16; i++) begin
        k = (m_rr + i) % 16;
        c = int'(entry_class[2*k +: 2]);
        if (entry_ready[k] && (m_credit[c] - g[c] > 0) && (n < 3)) begin
          ev[n]          = 1'b1;
          ei[n*4 +: 4]   = 4'(k);
          g[c]++;
          n++;
          last = k;
        end
      end
    end
    if (m_init || reset) begin
      chk("issue_valid", 32'(issue_valid), 32'(ev));
      chk("issue_idx", 32'(issue_idx), 32'(ei));
    end
    if (reset) begin
      for (int j = 0; j < 4; j++) m_credit[j] = 8;
      m_rr    = 0;
      m_err   = 1'b0;
      m_stall = '0;
      m_init  = 1'b1;
    end else if (squash) begin
      for (int j = 0; j < 4; j++) m_credit[j] = 8;
      m_rr    = 0;
      m_stall = '0;
    end else if (m_init) begin
      for (int j = 0; j < 4; j++) begin
        nx = m_credit[j] - g[j] + int'(fifo_pop[2*j +: 2]);
        if (nx > 8) begin
          nx    = 8;
          m_err = 1'b1;
        end else if (nx < 0) begin
          nx    = 0;
          m_err = 1'b1;
        end
        m_credit[j] = nx;
        m_stall[j]  = (nx < 3);
      end
      if (n > 0) m_rr = (last + 1) % 16;
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    entry_ready = '0;
    cyc();
    reset       = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset       = 1'b1;
    squash      = 1'b0;
    entry_ready = '0;
    entry_class = '0;
    fifo_pop    = '0;
    cyc();
    cyc();
    reset = 1'b0;

    // Three ALU entries from reset
    entry_ready = 16'h0007;
    entry_class = 32'h0;
    @(negedge clock);
    chk("t1_valid", 32'(issue_valid), 32'h7);
    chk("t1_idx", 32'(issue_idx), 32'h210);
    cyc();
    entry_ready = 16'h0009;
    @(negedge clock);
    chk("t1_credit_alu", 32'(credit[3:0]), 32'd5);
    chk("t1_rr_valid", 32'(issue_valid), 32'h3);
    chk("t1_rr_idx", 32'(issue_idx), 32'h003);
    cyc();

    // MULT credit of 1: one MULT granted, second skipped, ALU behind it granted
    do_reset();
    entry_class = 32'hAAAA_AAAA;
    entry_ready = 16'hFFFF;
    cyc();
    cyc();
    entry_ready = 16'h8000;
    cyc();
    entry_class = 32'h0000_000A;
    entry_ready = 16'h0007;
    @(negedge clock);
    chk("t2_credit_mult", 32'(credit[11:8]), 32'd1);
    chk("t2_valid", 32'(issue_valid), 32'h3);
    chk("t2_idx", 32'(issue_idx), 32'h020);
    cyc();
    entry_ready = '0;
    @(negedge clock);
    chk("t2_credit", 32'(credit), 32'h8087);
    chk("t2_stall", 32'(class_stall), 32'h4);
    cyc();

    // Wrap-around from entry 15 to 0
    do_reset();
    entry_class = 32'h0;
    entry_ready = 16'h2000;
    cyc();
    entry_class = 32'hFFFF_FFFF;
    entry_ready = 16'hC003;
    @(negedge clock);
    chk("t3_valid", 32'(issue_valid), 32'h7);
    chk("t3_idx", 32'(issue_idx), 32'h0FE);
    cyc();
    entry_ready = 16'h0003;
    @(negedge clock);
    chk("t3_wrap_valid", 32'(issue_valid), 32'h3);
    chk("t3_wrap_idx", 32'(issue_idx), 32'h001);
    chk("t3_credit_br", 32'(credit[15:12]), 32'd5);
    cyc();

    // LS credit exhausted; pops become usable only on the following cycle
    do_reset();
    entry_class = 32'h5555_5555;
    entry_ready = 16'hFFFF;
    cyc();
    cyc();
    cyc();
    entry_ready = 16'h0020;
    fifo_pop    = 8'h08;
    @(negedge clock);
    chk("t4_credit_ls0", 32'(credit[7:4]), 32'd0);
    chk("t4_stall_ls", 32'(class_stall[1]), 32'd1);
    chk("t4_no_grant", 32'(issue_valid), 32'h0);
    cyc();
    fifo_pop    = 8'h00;
    @(negedge clock);
    chk("t4_credit_ls2", 32'(credit[7:4]), 32'd2);
    chk("t4_valid", 32'(issue_valid), 32'h1);
    chk("t4_idx", 32'(issue_idx), 32'h005);
    cyc();
    entry_ready = '0;
    @(negedge clock);
    chk("t4_credit_ls1", 32'(credit[7:4]), 32'd1);
    cyc();

    // Squash with ALU entries ready
    do_reset();
    entry_class = 32'h0;
    entry_ready = 16'hFFFF;
    cyc();
    cyc();
    squash      = 1'b1;
    entry_ready = 16'h0007;
    @(negedge clock);
    chk("t5_credit_alu", 32'(credit[3:0]), 32'd2);
    chk("t5_valid", 32'(issue_valid), 32'h0);
    chk("t5_idx", 32'(issue_idx), 32'h0);
    cyc();
    squash      = 1'b0;
    entry_ready = 16'h8001;
    @(negedge clock);
    chk("t5_credit", 32'(credit), 32'h8888);
    chk("t5_rr_valid", 32'(issue_valid), 32'h3);
    chk("t5_rr_idx", 32'(issue_idx), 32'h0F0);
    cyc();

    // Overflow: pop at full credit
    do_reset();
    fifo_pop = 8'h01;
    cyc();
    fifo_pop = 8'h00;
    @(negedge clock);
    chk("t6_credit_alu", 32'(credit[3:0]), 32'd8);
    chk("t6_err", 32'(credit_err), 32'd1);
    squash = 1'b1;
    cyc();
    squash = 1'b0;
    @(negedge clock);
    chk("t6_err_squash", 32'(credit_err), 32'd1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clock);
    chk("t6_err_reset", 32'(credit_err), 32'd0);
    cyc();

    // Mixed traffic checked by the model alone
    for (int i = 0; i < 300; i++) begin
      entry_ready = 16'($urandom);
      entry_class = $urandom;
      fifo_pop    = 8'($urandom) & ((i % 40 < 20) ? 8'h55 : 8'hFF);
      squash      = ($urandom_range(0, 15) == 0);
      cyc();
    end
    squash      = 1'b0;
    entry_ready = '0;
    fifo_pop    = '0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
